// File: rtl/mac_kbd_fifo.sv
// mac_kbd_fifo: PS/2 key events to Mac transition codes through a queue, with paced command replies
module mac_kbd_fifo #(
  parameter int DEPTH = 8,
  parameter int SHORT_TICKS = 4095,
  parameter int LONG_TICKS = 4194303,
  parameter logic [7:0] MODEL_ID = 8'h03
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic [10:0]             ps2_key,
  output logic [8:0]              map_addr,
  input  logic [8:0]              map_data,
  input  logic [7:0]              data_out,
  input  logic                    strobe_out,
  output logic [7:0]              data_in,
  output logic                    strobe_in,
  output logic                    capslock,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(LONG_TICKS + 1);
  localparam logic [TW-1:0] SHORT = TW'(SHORT_TICKS);
  localparam logic [TW-1:0] LONG = TW'(LONG_TICKS);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  localparam logic [7:0] INQ = 8'h10;
  localparam logic [7:0] INST = 8'h14;
  localparam logic [7:0] MODEL = 8'h16;
  localparam logic [7:0] TEST = 8'h36;
  logic [8:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [7:0] cmd;
  logic [TW-1:0] timer, tnext;
  logic armed, old_stb, evt, ev_pressed, active;
  logic stb_edge, is_caps, push_req, empty, full, at_short, live;
  logic use_head, reply, flush, pop, clr_kp, do_push, map_unused;
  logic [8:0] push_val, head;
  logic [7:0] reply_val;
  assign map_unused = map_data[7];
  assign stb_edge = armed && (ps2_key[10] != old_stb);
  assign is_caps = map_addr == 9'h058;
  assign push_req = evt && (is_caps ? ev_pressed : map_data[6:0] != 7'h7B);
  assign push_val = is_caps ? {1'b0, capslock, 7'h73} : {map_data[8], ~ev_pressed, map_data[6:0]};
  assign empty = fifo_level == '0;
  assign full = fifo_level == FULL;
  assign head = mem[rd];
  assign tnext = timer == LONG ? timer : timer + 1'b1;
  assign at_short = tnext == SHORT;
  // a strobe in this cycle aborts whatever command was pending
  assign live = active && !strobe_out;
  assign use_head = live && !empty && ((cmd == INST && at_short) || (cmd == INQ && tnext >= SHORT));
  assign reply = use_head || (live && ((at_short && (cmd == INST || cmd == MODEL || cmd == TEST)) || (cmd == INQ && tnext == LONG)));
  assign reply_val = use_head ? (head[8] ? 8'h79 : head[7:0]) : cmd == MODEL ? MODEL_ID : cmd == TEST ? 8'h7D : 8'h7B;
  assign flush = reply && cmd == TEST;
  assign pop = use_head && !head[8];
  assign clr_kp = use_head && head[8];
  assign do_push = push_req && !full && !flush;
  // queue storage: keypad replies clear the kp flag in place instead of popping
  always_ff @(posedge clk) begin
    if (ce && do_push) mem[wr] <= push_val;
    if (ce && clr_kp) mem[rd][8] <= 1'b0;
  end
  // event capture, caps lock, queue pointers, command timer and reply register
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      armed <= 1'b0;
      old_stb <= 1'b0;
      evt <= 1'b0;
      ev_pressed <= 1'b0;
      map_addr <= '0;
      capslock <= 1'b0;
      overflow <= 1'b0;
      fifo_level <= '0;
      rd <= '0;
      wr <= '0;
      cmd <= '0;
      active <= 1'b0;
      timer <= '0;
      data_in <= 8'h7B;
      strobe_in <= 1'b0;
    end else begin
      strobe_in <= ce && reply;
      if (ce) begin
        armed <= 1'b1;
        old_stb <= ps2_key[10];
        evt <= stb_edge;
        if (stb_edge) begin
          map_addr <= ps2_key[8:0];
          ev_pressed <= ps2_key[9];
        end
        if (evt && is_caps && ev_pressed) capslock <= ~capslock;
        overflow <= flush ? 1'b0 : overflow || (push_req && full);
        timer <= strobe_out ? '0 : tnext;
        active <= strobe_out || (active && !reply);
        if (strobe_out) cmd <= data_out;
        if (reply) data_in <= reply_val;
        rd <= flush ? '0 : rd + AW'(pop);
        wr <= flush ? '0 : wr + AW'(do_push);
        fifo_level <= flush ? '0 : fifo_level + (AW + 1)'(do_push) - (AW + 1)'(pop);
      end
    end
endmodule

// File: tb/tb_mac_kbd_fifo.sv
// tb_mac_kbd_fifo: scenario tasks plus randomized traffic checked against a queue-based reference model
module tb_mac_kbd_fifo;
  localparam int DEPTH = 4;
  localparam int SHORT = 8;
  localparam int LONG = 64;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ce = 1'b1;
  logic strobe_out = 1'b0;
  logic [10:0] ps2_key = '0;
  logic [7:0] data_out = '0;
  logic [8:0] map_addr, map_data;
  logic [7:0] data_in;
  logic strobe_in, capslock, overflow;
  logic [2:0] fifo_level;
  logic [8:0] q[$];
  logic m_caps = 1'b0;
  logic m_ovf = 1'b0;
  int checks = 0;
  int errors = 0;

  mac_kbd_fifo #(.DEPTH(DEPTH), .SHORT_TICKS(SHORT), .LONG_TICKS(LONG), .MODEL_ID(8'h03)) dut (
    .clk(clk), .reset(reset), .ce(ce), .ps2_key(ps2_key), .map_addr(map_addr), .map_data(map_data),
    .data_out(data_out), .strobe_out(strobe_out), .data_in(data_in), .strobe_in(strobe_in),
    .capslock(capslock), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] rom(input logic [8:0] a);
    if (a == 9'h01C) return 9'h001;
    if (a == 9'h069) return 9'h127;
    if (a == 9'h058) return 9'h039;
    if (!a[8] && a[7:0] >= 8'h10 && a[7:0] < 8'h50) return {2'b00, a[6:0]};
    return 9'h07B;
  endfunction

  assign map_data = rom(map_addr);

  task automatic model_push(input logic [8:0] v);
    if (q.size() >= DEPTH) m_ovf = 1'b1;
    else q.push_back(v);
  endtask

  task automatic model_key(input logic p, input logic e, input logic [7:0] sc);
    logic [8:0] m;
    if (!e && sc == 8'h58) begin
      if (p) begin
        model_push({1'b0, m_caps, 7'h73});
        m_caps = ~m_caps;
      end
    end else begin
      m = rom({e, sc});
      if (m[6:0] != 7'h7B) model_push({m[8], ~p, m[6:0]});
    end
  endtask

  task automatic model_reply(output logic [7:0] r);
    logic [8:0] h;
    if (q.size() == 0) r = 8'h7B;
    else if (q[0][8]) begin
      r = 8'h79;
      h = q[0];
      h[8] = 1'b0;
      q[0] = h;
    end else begin
      r = q[0][7:0];
      void'(q.pop_front());
    end
  endtask

  task automatic key_drive(input logic p, input logic e, input logic [7:0] sc);
    ps2_key = {~ps2_key[10], p, e, sc};
    model_key(p, e, sc);
  endtask

  task automatic key(input logic p, input logic e, input logic [7:0] sc);
    @(negedge clk);
    key_drive(p, e, sc);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  // iteration n observes the state after the (n-1)-th edge following the command edge
  task automatic run_cmd(input logic [7:0] b, input int inj_n, input int inj_kind, input logic [7:0] inj_sc,
                         input logic [7:0] inj_cmd, output int lat, output logic [7:0] d);
    @(negedge clk);
    data_out = b;
    strobe_out = 1'b1;
    lat = -1;
    d = 8'hxx;
    for (int n = 1; n <= LONG + 8 && lat < 0; n++) begin
      @(negedge clk);
      strobe_out = 1'b0;
      if (strobe_in) begin
        lat = n;
        d = data_in;
      end
      if (n == inj_n && inj_kind == 1) key_drive(1'b1, 1'b0, inj_sc);
      if (n == inj_n && inj_kind == 2) begin
        data_out = inj_cmd;
        strobe_out = 1'b1;
      end
    end
  endtask

  task automatic count_pulses(input int cycles, output int c);
    c = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (strobe_in) c++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (data_in !== 8'h7B) begin errors++; $display("FAIL rst_data_in got %h want 7b", data_in); end
    checks++; if (strobe_in !== 1'b0) begin errors++; $display("FAIL rst_strobe_in got %b want 0", strobe_in); end
    checks++; if (capslock !== 1'b0) begin errors++; $display("FAIL rst_capslock got %b want 0", capslock); end
    checks++; if (map_addr !== 9'h0) begin errors++; $display("FAIL rst_map_addr got %h want 000", map_addr); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d want 0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b want 0", overflow); end
    reset = 1'b0;
    settle();
  endtask

  task automatic test_model();
    int lat;
    logic [7:0] d;
    run_cmd(8'h16, 0, 0, 8'h00, 8'h00, lat, d);
    checks++; if (lat !== SHORT + 1) begin errors++; $display("FAIL model_lat got %0d want %0d", lat, SHORT + 1); end
    checks++; if (d !== 8'h03) begin errors++; $display("FAIL model_data got %h want 03", d); end
    @(negedge clk);
    checks++; if (strobe_in !== 1'b0) begin errors++; $display("FAIL model_pulse_width got %b want 0", strobe_in); end
    key(1'b1, 1'b0, 8'h20);
    key(1'b1, 1'b0, 8'h21);
    settle();
    checks++; if (fifo_level !== 3'(q.size())) begin errors++; $display("FAIL pretest_level got %0d want %0d", fifo_level, q.size()); end
    run_cmd(8'h36, 0, 0, 8'h00, 8'h00, lat, d);
    q.delete();
    m_ovf = 1'b0;
    checks++; if (lat !== SHORT + 1) begin errors++; $display("FAIL test_lat got %0d want %0d", lat, SHORT + 1); end
    checks++; if (d !== 8'h7D) begin errors++; $display("FAIL test_data got %h want 7d", d); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL test_level got %0d want 0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL test_overflow got %b want 0", overflow); end
  endtask

  task automatic test_inquiry();
    int lat;
    logic [7:0] d, e;
    run_cmd(8'h10, 0, 0, 8'h00, 8'h00, lat, d);
    checks++; if (lat !== LONG + 1) begin errors++; $display("FAIL inq_timeout_lat got %0d want %0d", lat, LONG + 1); end
    checks++; if (d !== 8'h7B) begin errors++; $display("FAIL inq_timeout_data got %h want 7b", d); end
    run_cmd(8'h10, 20, 1, 8'h1C, 8'h00, lat, d);
    model_reply(e);
    checks++; if (lat !== 23) begin errors++; $display("FAIL inq_late_lat got %0d want 23", lat); end
    checks++; if (d !== e) begin errors++; $display("FAIL inq_late_data got %h want %h", d, e); end
    checks++; if (fifo_level !== 3'(q.size())) begin errors++; $display("FAIL inq_late_level got %0d want %0d", fifo_level, q.size()); end
  endtask

  task automatic test_keypad();
    int lat;
    logic [7:0] d, e;
    key(1'b1, 1'b0, 8'h69);
    settle();
    for (int i = 0; i < 2; i++) begin
      run_cmd(8'h14, 0, 0, 8'h00, 8'h00, lat, d);
      model_reply(e);
      checks++; if (d !== e) begin errors++; $display("FAIL kp_press_%0d got %h want %h", i, d, e); end
      checks++; if (fifo_level !== 3'(q.size())) begin errors++; $display("FAIL kp_level_%0d got %0d want %0d", i, fifo_level, q.size()); end
    end
    key(1'b0, 1'b0, 8'h69);
    settle();
    for (int i = 0; i < 2; i++) begin
      run_cmd(8'h14, 0, 0, 8'h00, 8'h00, lat, d);
      model_reply(e);
      checks++; if (d !== e) begin errors++; $display("FAIL kp_release_%0d got %h want %h", i, d, e); end
    end
  endtask

  task automatic test_burst();
    int lat;
    logic [7:0] d, e;
    int off;
    off = int'($urandom_range(0, 3));
    for (int i = 0; i < 6; i++) key(1'b1, 1'b0, 8'(8'h10 + i * 5 + off));
    settle();
    checks++; if (fifo_level !== 3'(q.size())) begin errors++; $display("FAIL burst_level got %0d want %0d", fifo_level, q.size()); end
    checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL burst_overflow got %b want %b", overflow, m_ovf); end
    for (int i = 0; i < 5; i++) begin
      run_cmd(8'h14, 0, 0, 8'h00, 8'h00, lat, d);
      model_reply(e);
      checks++; if (d !== e) begin errors++; $display("FAIL burst_pop_%0d got %h want %h", i, d, e); end
    end
    run_cmd(8'h36, 0, 0, 8'h00, 8'h00, lat, d);
    q.delete();
    m_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL burst_ovf_clear got %b want 0", overflow); end
  endtask

  task automatic test_caps();
    int lat;
    logic [7:0] d, e;
    key(1'b1, 1'b0, 8'h58);
    settle();
    checks++; if (capslock !== m_caps) begin errors++; $display("FAIL caps_on got %b want %b", capslock, m_caps); end
    key(1'b0, 1'b0, 8'h58);
    key(1'b1, 1'b0, 8'h58);
    key(1'b1, 1'b0, 8'h05);
    settle();
    checks++; if (capslock !== m_caps) begin errors++; $display("FAIL caps_off got %b want %b", capslock, m_caps); end
    checks++; if (fifo_level !== 3'(q.size())) begin errors++; $display("FAIL caps_level got %0d want %0d", fifo_level, q.size()); end
    for (int i = 0; i < 3; i++) begin
      run_cmd(8'h14, 0, 0, 8'h00, 8'h00, lat, d);
      model_reply(e);
      checks++; if (d !== e) begin errors++; $display("FAIL caps_pop_%0d got %h want %h", i, d, e); end
    end
  endtask

  task automatic test_abort();
    int lat, c;
    logic [7:0] d;
    run_cmd(8'h10, 4, 2, 8'h00, 8'h16, lat, d);
    checks++; if (lat !== 13) begin errors++; $display("FAIL abort_lat got %0d want 13", lat); end
    checks++; if (d !== 8'h03) begin errors++; $display("FAIL abort_data got %h want 03", d); end
    count_pulses(LONG + 16, c);
    checks++; if (c !== 0) begin errors++; $display("FAIL abort_extra_pulses got %0d want 0", c); end
  endtask

  task automatic test_reset_mid();
    int c;
    for (int i = 0; i < 4; i++) key(1'b1, 1'b0, 8'(8'h30 + i));
    key(1'b1, 1'b0, 8'h58);
    settle();
    checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL pre_rst_overflow got %b want %b", overflow, m_ovf); end
    checks++; if (capslock !== m_caps) begin errors++; $display("FAIL pre_rst_caps got %b want %b", capslock, m_caps); end
    @(negedge clk);
    data_out = 8'h16;
    strobe_out = 1'b1;
    @(negedge clk);
    strobe_out = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (data_in !== 8'h7B) begin errors++; $display("FAIL mid_rst_data_in got %h want 7b", data_in); end
    checks++; if (capslock !== 1'b0) begin errors++; $display("FAIL mid_rst_caps got %b want 0", capslock); end
    checks++; if (map_addr !== 9'h0) begin errors++; $display("FAIL mid_rst_map_addr got %h want 000", map_addr); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL mid_rst_level got %0d want 0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_rst_overflow got %b want 0", overflow); end
    ps2_key[10] = ~ps2_key[10];
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    m_caps = 1'b0;
    m_ovf = 1'b0;
    count_pulses(20, c);
    checks++; if (c !== 0) begin errors++; $display("FAIL post_rst_pulses got %0d want 0", c); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL post_rst_spurious got %0d want 0", fifo_level); end
    key(1'b1, 1'b0, 8'h1C);
    settle();
    checks++; if (fifo_level !== 3'(q.size())) begin errors++; $display("FAIL post_rst_key got %0d want %0d", fifo_level, q.size()); end
  endtask

  task automatic test_flush_push();
    int lat;
    logic [7:0] d;
    run_cmd(8'h36, 7, 1, 8'h1C, 8'h00, lat, d);
    q.delete();
    m_ovf = 1'b0;
    checks++; if (d !== 8'h7D) begin errors++; $display("FAIL flush_push_data got %h want 7d", d); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL flush_push_level got %0d want 0", fifo_level); end
    settle();
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL flush_push_late got %0d want 0", fifo_level); end
  endtask

  task automatic test_random();
    int lat, exp_lat, r;
    logic [7:0] d, e, sc;
    logic [7:0] c;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        r = int'($urandom_range(0, 9));
        sc = r == 0 ? 8'h69 : r == 1 ? 8'h05 : 8'($urandom_range(8'h10, 8'h4F));
        key(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, sc);
        settle();
        checks++; if (fifo_level !== 3'(q.size())) begin errors++; $display("FAIL rnd_key_level_%0d got %0d want %0d", i, fifo_level, q.size()); end
      end else begin
        c = $urandom_range(0, 1) != 0 ? 8'h14 : 8'h10;
        exp_lat = (c == 8'h10 && q.size() == 0) ? LONG + 1 : SHORT + 1;
        run_cmd(c, 0, 0, 8'h00, 8'h00, lat, d);
        model_reply(e);
        checks++; if (lat !== exp_lat || d !== e) begin errors++; $display("FAIL rnd_cmd_%0d cmd %h got lat %0d data %h want lat %0d data %h", i, c, lat, d, exp_lat, e); end
        checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow_%0d got %b want %b", i, overflow, m_ovf); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_model();
    test_inquiry();
    test_keypad();
    test_burst();
    test_caps();
    test_abort();
    test_reset_mid();
    test_flush_push();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
